tt_um_fifo_flags: RTL
=====================

Name: tt_um_fifo_flags

Overview:
- Parametrised synchronous FIFO, successor to the single-bit 32-entry FIFO.
- Adds configurable width and depth, a fill count, and programmable almost-full / almost-empty thresholds.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a read-data valid strobe.
- Sits between a producer and consumer in the same clock domain; used as the standard elastic buffer in the tapeout top.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, 2..256.
- AFULL_THRESH, 12, almost_full asserts when count >= this value (1..DEPTH).
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value (0..DEPTH-1).
- Derived (not overridable): AW = log2(DEPTH). CW = AW+1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of FIFO state
- wr_en  input  1  write request
- wr_data  input  WIDTH  write data
- rd_en  input  1  read request
- rd_data  output  WIDTH  registered read data
- rd_valid  output  1  rd_data updated by a read this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_THRESH
- almost_empty  output  1  count <= AEMPTY_THRESH
- count  output  CW  current number of stored entries
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers, count, rd_data, rd_valid, overflow and underflow all go to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.
- Pointers: rd_ptr and wr_ptr are AW+1 bits. The low AW bits address memory; the MSB is the wrap bit. Wrap DEPTH-1 -> 0 toggles the MSB.
- Write accept: wr_acc = wr_en & ~full. On the edge, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept: rd_acc = rd_en & ~empty.
  - On the edge, rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds.
  - Latency: data is visible on rd_data and rd_valid in the cycle after rd_acc.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Simultaneous read and write:
  - Not full and not empty: both accepted; count unchanged.
  - Empty: only the write is accepted (no read-through); underflow sets.
  - Full: only the read is accepted; overflow sets.
- Flags: full, empty, almost_full and almost_empty are decoded from the count register, so they change on the same edge as count. No flag lags count by a cycle.
- Error flags:
  - overflow <= 1 when wr_en & full; underflow <= 1 when rd_en & empty.
  - Both are sticky and cleared only by flush or reset.
  - A rejected access changes no pointer, count or data.
- flush (synchronous): pointers, count, rd_valid, overflow and underflow go to 0.
  - Flush has priority over wr_en/rd_en in the same cycle; both are ignored.
  - rd_data holds its last value.
- count is never allowed to exceed DEPTH or go below 0.

Test Plan:
- Write 16 words 0x10..0x1F with no reads -> count 1..16; almost_full rises when count reaches 12; full=1 at 16; then wr_en with 0xAA -> overflow=1, count stays 16, no data change.
- From full, read 16 times -> rd_data 0x10..0x1F in order, each one cycle after rd_en with rd_valid=1; almost_empty at count<=2; empty at 0; extra rd_en -> underflow=1, rd_valid=0.
- Hold count at 5, then assert wr_en and rd_en together for 20 cycles -> count stays 5, output data in order, pointers wrap past 15 without error.
- Empty FIFO, wr_en and rd_en together with 0x55 -> write accepted, count=1, underflow=1, rd_valid=0 next cycle; following read returns 0x55.
- Count 7 and overflow set; assert flush together with wr_en -> count=0, empty=1, overflow=0, write ignored.
- Pull reset_n low between clock edges mid-burst at count 9 -> all outputs reach reset values before the next edge; a subsequent write/read returns the new data only.

Source files
------------

// File: rtl/tt_um_fifo_flags.sv
// Parametrised single-clock FIFO with fill count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and a read-valid strobe.
module tt_um_fifo_flags #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned AFULL_THRESH  = 12,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      rd_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_acc;
   logic             rd_acc;
   logic [CW-1:0]    count_nxt;

   // Accepts are qualified by the registered flags; flush masks both requests.
   always_comb begin
      wr_acc = 1'b0;
      rd_acc = 1'b0;
      if (!flush) begin
         wr_acc = wr_en & ~full;
         rd_acc = rd_en & ~empty;
      end
   end

   // Next fill level; flags are registered from this so they move with count.
   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else begin
         unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
         endcase
      end
   end

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + CW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + CW'(1);
         end
      end
   end

   // Read port: rd_data holds across idle cycles and flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         count        <= count_nxt;
         full         <= (count_nxt == CW'(DEPTH));
         empty        <= (count_nxt == CW'(0));
         almost_full  <= (count_nxt >= CW'(AFULL_THRESH));
         almost_empty <= (count_nxt <= CW'(AEMPTY_THRESH));
      end
   end

   // Sticky error flags, cleared only by flush or reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule
